hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Producer of the RAW forwarding controls consumed by the decode stage: the RAW_hazards and RAW_mem_wb_hazards buses, plus we_valid.
- Tracks the destination register, write-back and load attributes of instructions in EX, MEM and WB with a 3-slot shift pipeline.
- Compares the tracked slots against rs1/rs2 of the instruction in decode.
- Generates the load-use stall, the EX bubble and flush squashing for the 5-stage core.

Parameters:
- REG_ADDR_W, 5, register address width.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- valid_dec  input  1  decode holds a real instruction.
- rs1_dec  input  REG_ADDR_W  decode rs1 (already forced to 0 for LUI).
- rs2_dec  input  REG_ADDR_W  decode rs2.
- rd_dec  input  REG_ADDR_W  decode rd.
- rf_wb_dec  input  1  decode instruction writes the register file.
- mem_load_dec  input  1  decode instruction is a load.
- flush  input  1  taken branch/jump resolved; squash the decode instruction.
- RAW_hazards  output  4  {rs1_ex,rs2_ex,rs1_mem,rs2_mem}.
- RAW_mem_wb_hazards  output  2  {load_raw_wb_dec_rs1,load_raw_wb_dec_rs2}.
- we_valid  output  1  WB slot holds a valid writing instruction.
- stall  output  1  hold the PC and the IF/DEC register.
- bubble_ex  output  1  insert a NOP into the ID/EX register.

Behaviour:
- Slot format: each of EX, MEM, WB holds {v, rd, wb, ld}. Reset clears all fields to 0.
- Outputs after reset: all outputs 0.
- Slot update on every clk:
  - WB<=MEM and MEM<=EX, always.
  - EX<={valid_dec,rd_dec,rf_wb_dec,mem_load_dec} when !stall && !flush; otherwise EX<=0 (bubble).
- Match condition for slot S and source x: S.v & S.wb & (S.rd!=0) & (S.rd==x). A destination of x0 never matches.
- EX-stage flags (combinational from slot state and the current decode inputs, zero latency):
  - rs1_ex = valid_dec & match(EX,rs1_dec) & !EX.ld.
  - rs2_ex is the same check for rs2.
- MEM-stage flags:
  - rs1_mem = valid_dec & match(MEM,rs1_dec) & !MEM.ld & !match(EX,rs1_dec).
  - rs2_mem is the same check for rs2.
  - The youngest producer wins.
- WB load flags:
  - load_raw_wb_dec_rs1 = valid_dec & match(WB,rs1_dec) & WB.ld & !match(EX,rs1_dec) & !match(MEM,rs1_dec).
  - The rs2 flag is the same check. Decode then takes the register file value through its WB bypass.
- Load-use stall:
  - Stall condition: valid_dec & !flush & (match(EX,rsX) & EX.ld | match(MEM,rsX) & MEM.ld), for X = 1 or 2.
  - bubble_ex = stall | flush.
  - While stall is high, all forwarding flags for the stalled instruction stay as computed. They are ignored downstream because EX receives a bubble.
- Stall FSM, for observability and checking:
  - States: RUN, LU2 (load in EX), LU1 (load in MEM).
  - RUN->LU2 on an EX load match; RUN->LU1 on a MEM-only load match.
  - LU2->LU1 unconditionally; LU1->RUN unconditionally.
  - flush in any state -> RUN.
  - stall must equal (state!=RUN next-cycle precondition). The FSM state must agree with the slot-derived condition; an assertion checks this.
- Latency: a load followed immediately by a dependent instruction gives stall for 2 cycles, then load_raw_wb asserted for 1 cycle. With one independent instruction in between: 1 stall cycle.
- flush during a stall:
  - Stall drops the same cycle and the EX bubble is inserted.
  - The decode instruction is replaced by IF (controlled externally).
- we_valid = WB.v & WB.wb.
- rst mid-stall: next cycle all slots are 0, FSM is RUN, all outputs are 0.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[CNT_W-1:0] and fwd_cnt[CNT_W-1:0].
  - stall_cnt increments on every cycle with stall=1.
  - fwd_cnt increments on every cycle where any RAW_hazards bit is set and stall=0.
  - Both counters saturate at all-ones and clear on rst.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- ADD x5 then ADD x6,x5,x5 back-to-back -> RAW_hazards=4'b1100 in the second instruction's decode cycle; stall=0.
- ADD x5; NOP; SUB x7,x5,x1 -> RAW_hazards=4'b0010; stall=0.
- LW x8; ADD x9,x8,x0 -> stall=1 for 2 cycles, bubble_ex=1 for both, FSM RUN->LU2->LU1->RUN, then RAW_mem_wb_hazards=2'b10 for 1 cycle.
- ADDI x0,x0,1 followed by a reader of x0 -> all hazard outputs 0. Also: ADD x3 then ADD x3 then a reader of x3 -> only the EX flag is set (youngest wins).
- LW x4; BEQ-dependent instruction with flush asserted in the first stall cycle -> stall drops the same cycle, EX slot=0 next cycle. Also: rst asserted in LU2 -> all outputs 0 the next cycle.
- With HAZ_PERF_CNT_EN: the LW-use sequence run 3 times -> stall_cnt=6. Also: a counter preloaded near all-ones saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
// RAW hazard detection and forwarding control for a 5-stage in-order core.
// Tracks {valid, rd, writes-rf, is-load} for the instructions in EX, MEM and
// WB, and compares them against the decode-stage sources to produce the
// forwarding selects, the load-use stall and the EX bubble.
// Optional: define HAZ_PERF_CNT_EN to add saturating stall/forward counters.
module hazard_forward_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_dec,
    input  logic [REG_ADDR_W-1:0] rs1_dec,
    input  logic [REG_ADDR_W-1:0] rs2_dec,
    input  logic [REG_ADDR_W-1:0] rd_dec,
    input  logic                  rf_wb_dec,
    input  logic                  mem_load_dec,
    input  logic                  flush,
    output logic [3:0]            RAW_hazards,
    output logic [1:0]            RAW_mem_wb_hazards,
    output logic                  we_valid,
    output logic                  stall,
    output logic                  bubble_ex
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
`endif
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wb;
        logic                  ld;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_LU2 = 2'd1,
        ST_LU1 = 2'd2
    } state_t;

    slot_t  r_ex;
    slot_t  r_mem;
    slot_t  r_wb;
    slot_t  w_ex_nxt;

    state_t r_state;
    state_t w_state_nxt;

    logic   w_ex_rs1;
    logic   w_ex_rs2;
    logic   w_mem_rs1;
    logic   w_mem_rs2;
    logic   w_wb_rs1;
    logic   w_wb_rs2;

    logic   w_fwd_ex_rs1;
    logic   w_fwd_ex_rs2;
    logic   w_fwd_mem_rs1;
    logic   w_fwd_mem_rs2;
    logic   w_ld_wb_rs1;
    logic   w_ld_wb_rs2;

    logic   w_lu_ex;
    logic   w_lu_mem;
    logic   w_stall;

    // A slot supplies source x only if it is a live register-file writer;
    // x0 is hard-wired and is never a producer.
    function automatic logic f_match(input slot_t s, input logic [REG_ADDR_W-1:0] x);
        return s.v & s.wb & (s.rd != '0) & (s.rd == x);
    endfunction

    assign w_ex_rs1  = f_match(r_ex,  rs1_dec);
    assign w_ex_rs2  = f_match(r_ex,  rs2_dec);
    assign w_mem_rs1 = f_match(r_mem, rs1_dec);
    assign w_mem_rs2 = f_match(r_mem, rs2_dec);
    assign w_wb_rs1  = f_match(r_wb,  rs1_dec);
    assign w_wb_rs2  = f_match(r_wb,  rs2_dec);

    // Forwarding selects: the youngest matching producer wins; load results
    // are not available in EX/MEM and come through the WB bypass instead.
    always_comb begin
        w_fwd_ex_rs1  = valid_dec & w_ex_rs1 & ~r_ex.ld;
        w_fwd_ex_rs2  = valid_dec & w_ex_rs2 & ~r_ex.ld;
        w_fwd_mem_rs1 = valid_dec & w_mem_rs1 & ~r_mem.ld & ~w_ex_rs1;
        w_fwd_mem_rs2 = valid_dec & w_mem_rs2 & ~r_mem.ld & ~w_ex_rs2;
        w_ld_wb_rs1   = valid_dec & w_wb_rs1 & r_wb.ld & ~w_ex_rs1 & ~w_mem_rs1;
        w_ld_wb_rs2   = valid_dec & w_wb_rs2 & r_wb.ld & ~w_ex_rs2 & ~w_mem_rs2;
    end

    // Load-use detection: a load still in EX or MEM cannot be forwarded yet.
    always_comb begin
        w_lu_ex  = valid_dec & (w_ex_rs1  | w_ex_rs2)  & r_ex.ld;
        w_lu_mem = valid_dec & (w_mem_rs1 | w_mem_rs2) & r_mem.ld;
        w_stall  = ~flush & (w_lu_ex | w_lu_mem);
    end

    // Next EX slot: decode instruction, or a bubble when stalled or squashed.
    always_comb begin
        w_ex_nxt = '0;
        if (!w_stall && !flush) begin
            w_ex_nxt = {valid_dec, rd_dec, rf_wb_dec, mem_load_dec};
        end
    end

    // Three-slot tracking pipeline EX -> MEM -> WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_ex_nxt;
        end
    end

    // Stall FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stall FSM next state: LU2 means the load was in EX, so one more stall
    // cycle follows; LU1 is the release cycle after the last stall.
    always_comb begin
        w_state_nxt = ST_RUN;
        if (!flush) begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_lu_ex) begin
                        w_state_nxt = ST_LU2;
                    end else if (w_lu_mem) begin
                        w_state_nxt = ST_LU1;
                    end
                end
                ST_LU2:  w_state_nxt = ST_LU1;
                ST_LU1:  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // The slot-derived stall and the FSM sequencing must always agree.
    a_stall_fsm : assert property (@(posedge clk) disable iff (rst)
        w_stall == (w_state_nxt != ST_RUN));

    assign RAW_hazards        = {w_fwd_ex_rs1, w_fwd_ex_rs2, w_fwd_mem_rs1, w_fwd_mem_rs2};
    assign RAW_mem_wb_hazards = {w_ld_wb_rs1, w_ld_wb_rs2};
    assign we_valid           = r_wb.v & r_wb.wb;
    assign stall              = w_stall;
    assign bubble_ex          = w_stall | flush;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;

    // Saturating performance counters: stall cycles and forwarded cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!w_stall && (|RAW_hazards) && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`else
    if (CNT_W == 0) begin : g_no_perf_cnt
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl
// Directed table of decode cycles with hand-computed expectations, followed
// by randomized decode traffic checked against a producer-search model.
module tb_hazard_forward_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;
    localparam int NV = 24;
    localparam int NRND = 3000;

    logic          clk;
    logic          rst;
    logic          valid_dec;
    logic [RW-1:0] rs1_dec;
    logic [RW-1:0] rs2_dec;
    logic [RW-1:0] rd_dec;
    logic          rf_wb_dec;
    logic          mem_load_dec;
    logic          flush;
    logic [3:0]    RAW_hazards;
    logic [1:0]    RAW_mem_wb_hazards;
    logic          we_valid;
    logic          stall;
    logic          bubble_ex;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] fwd_cnt;
`endif

    hazard_forward_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_dec          (valid_dec),
        .rs1_dec            (rs1_dec),
        .rs2_dec            (rs2_dec),
        .rd_dec             (rd_dec),
        .rf_wb_dec          (rf_wb_dec),
        .mem_load_dec       (mem_load_dec),
        .flush              (flush),
        .RAW_hazards        (RAW_hazards),
        .RAW_mem_wb_hazards (RAW_mem_wb_hazards),
        .we_valid           (we_valid),
        .stall              (stall),
        .bubble_ex          (bubble_ex)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt          (stall_cnt),
        .fwd_cnt            (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the last three issued instructions, index 0 = youngest (EX).
    typedef struct packed {
        logic          v;
        logic [RW-1:0] rd;
        logic          wb;
        logic          ld;
    } ins_t;

    ins_t hist [3];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic          r;
        logic          v;
        logic [RW-1:0] a;
        logic [RW-1:0] b;
        logic [RW-1:0] d;
        logic          w;
        logic          l;
        logic          f;
        logic          chk;
        logic [3:0]    raw;
        logic [1:0]    mwb;
        logic          we;
        logic          st;
        logic          bub;
        logic          sc;
        logic [1:0]    est;
        logic          exz;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t row(input int r, input int v, input int a, input int b,
                                 input int d, input int w, input int l, input int f,
                                 input int raw, input int mwb, input int we,
                                 input int st, input int bub, input int est, input int exz);
        vec_t x;
        x.r   = r[0];
        x.v   = v[0];
        x.a   = a[RW-1:0];
        x.b   = b[RW-1:0];
        x.d   = d[RW-1:0];
        x.w   = w[0];
        x.l   = l[0];
        x.f   = f[0];
        x.chk = (raw >= 0);
        x.raw = raw[3:0];
        x.mwb = mwb[1:0];
        x.we  = we[0];
        x.st  = st[0];
        x.bub = bub[0];
        x.sc  = (est >= 0);
        x.est = est[1:0];
        x.exz = exz[0];
        return x;
    endfunction

    function automatic bit writes(input int k, input logic [RW-1:0] r);
        return hist[k].v && hist[k].wb && (hist[k].rd != '0) && (hist[k].rd == r);
    endfunction

    task automatic model_eval(output logic [3:0] raw, output logic [1:0] mwb,
                              output logic we, output logic st, output logic bub);
        logic [1:0]    ex_f;
        logic [1:0]    mem_f;
        logic [1:0]    wb_f;
        logic          lu;
        logic [RW-1:0] src;
        int            y;
        lu = 1'b0;
        for (int s = 0; s < 2; s++) begin
            src = (s == 0) ? rs1_dec : rs2_dec;
            y = -1;
            for (int k = 2; k >= 0; k--) begin
                if (writes(k, src)) y = k;
            end
            ex_f[1-s]  = valid_dec && (y == 0) && !hist[0].ld;
            mem_f[1-s] = valid_dec && (y == 1) && !hist[1].ld;
            wb_f[1-s]  = valid_dec && (y == 2) && hist[2].ld;
            if (valid_dec && ((writes(0, src) && hist[0].ld) || (writes(1, src) && hist[1].ld)))
                lu = 1'b1;
        end
        raw = {ex_f, mem_f};
        mwb = wb_f;
        we  = hist[2].v && hist[2].wb;
        st  = !flush && lu;
        bub = st || flush;
    endtask

    task automatic tick();
        logic [3:0] raw;
        logic [1:0] mwb;
        logic       we, st, bub;
        model_eval(raw, mwb, we, st, bub);
        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = '0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (st || flush) ? ins_t'('0) : {valid_dec, rd_dec, rf_wb_dec, mem_load_dec};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [RW-1:0] a,
                         input logic [RW-1:0] b, input logic [RW-1:0] d,
                         input logic w, input logic l, input logic f);
        rst          = r;
        valid_dec    = v;
        rs1_dec      = a;
        rs2_dec      = b;
        rd_dec       = d;
        rf_wb_dec    = w;
        mem_load_dec = l;
        flush        = f;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [3:0] m_raw;
        logic [1:0] m_mwb;
        logic       m_we, m_st, m_bub;
        logic       hold;

        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) hist[k] = '0;

        //              r v rs1 rs2 rd w l f   raw      mwb   we st bu  est exz
        tbl[0]  = row(1,0, 0, 0, 0,0,0,0,     -1,       0,    0, 0, 0, -1, 0);
        tbl[1]  = row(0,0, 0, 0, 0,0,0,0,      0,       0,    0, 0, 0,  0, 1);
        tbl[2]  = row(0,1, 1, 2, 5,1,0,0,      0,       0,    0, 0, 0, -1, 0);
        tbl[3]  = row(0,1, 5, 5, 6,1,0,0,      4'b1100, 0,    0, 0, 0, -1, 0);
        tbl[4]  = row(0,1, 0, 0, 5,1,0,0,      0,       0,    0, 0, 0, -1, 0);
        tbl[5]  = row(0,1, 0, 0, 0,1,0,0,      0,       0,    1, 0, 0, -1, 0);
        tbl[6]  = row(0,1, 5, 1, 7,1,0,0,      4'b0010, 0,    1, 0, 0, -1, 0);
        tbl[7]  = row(0,1, 2, 0, 8,1,1,0,      0,       0,    1, 0, 0, -1, 0);
        tbl[8]  = row(0,1, 8, 0, 9,1,0,0,      0,       0,    1, 1, 1,  0, 0);
        tbl[9]  = row(0,1, 8, 0, 9,1,0,0,      0,       0,    1, 1, 1,  1, 0);
        tbl[10] = row(0,1, 8, 0, 9,1,0,0,      0,       2'b10,1, 0, 0,  2, 0);
        tbl[11] = row(0,1, 0, 0, 0,1,0,0,      0,       0,    0, 0, 0,  0, 0);
        tbl[12] = row(0,1, 0, 0,10,1,0,0,      0,       0,    0, 0, 0, -1, 0);
        tbl[13] = row(0,1, 0, 0, 3,1,0,0,      0,       0,    1, 0, 0, -1, 0);
        tbl[14] = row(0,1, 0, 0, 3,1,0,0,      0,       0,    1, 0, 0, -1, 0);
        tbl[15] = row(0,1, 3, 3,11,1,0,0,      4'b1100, 0,    1, 0, 0, -1, 0);
        tbl[16] = row(0,1, 0, 0, 4,1,1,0,      0,       0,    1, 0, 0, -1, 0);
        tbl[17] = row(0,1, 4, 4, 0,0,0,1,      0,       0,    1, 0, 1,  0, 0);
        tbl[18] = row(0,0, 0, 0, 0,0,0,0,      0,       0,    1, 0, 0,  0, 1);
        tbl[19] = row(0,1, 0, 0,12,1,1,0,      0,       0,    1, 0, 0, -1, 0);
        tbl[20] = row(0,1,12, 0,13,1,0,0,      0,       0,    0, 1, 1,  0, 0);
        tbl[21] = row(1,1,12, 0,13,1,0,0,      0,       0,    0, 1, 1,  1, 0);
        tbl[22] = row(0,1,12, 0,13,1,0,0,      0,       0,    0, 0, 0,  0, 1);
        tbl[23] = row(0,0, 0, 0, 0,0,0,0,      0,       0,    0, 0, 0,  0, 0);

        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].d,
                  tbl[i].w, tbl[i].l, tbl[i].f);
            #3;
            if (tbl[i].chk) begin
                chk($sformatf("row%0d RAW_hazards", i), 8'(RAW_hazards), 8'(tbl[i].raw));
                chk($sformatf("row%0d RAW_mem_wb", i), 8'(RAW_mem_wb_hazards), 8'(tbl[i].mwb));
                chk($sformatf("row%0d we_valid", i), 8'(we_valid), 8'(tbl[i].we));
                chk($sformatf("row%0d stall", i), 8'(stall), 8'(tbl[i].st));
                chk($sformatf("row%0d bubble_ex", i), 8'(bubble_ex), 8'(tbl[i].bub));
            end
            if (tbl[i].sc)
                chk($sformatf("row%0d fsm_state", i), 8'(dut.r_state), 8'(tbl[i].est));
            if (tbl[i].exz)
                chk($sformatf("row%0d ex_slot", i), 8'(dut.r_ex), 8'h00);
            tick();
        end

        // Randomized traffic; decode is held while the pipeline is stalled.
        hold = 1'b0;
        for (int c = 0; c < NRND; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if (!hold) begin
                valid_dec    = ($urandom_range(0, 7) != 0);
                rs1_dec      = RW'($urandom_range(0, 7));
                rs2_dec      = RW'($urandom_range(0, 7));
                rd_dec       = RW'($urandom_range(0, 7));
                rf_wb_dec    = ($urandom_range(0, 3) != 0);
                mem_load_dec = ($urandom_range(0, 2) == 0);
            end
            #3;
            model_eval(m_raw, m_mwb, m_we, m_st, m_bub);
            chk("rnd RAW_hazards", 8'(RAW_hazards), 8'(m_raw));
            chk("rnd RAW_mem_wb", 8'(RAW_mem_wb_hazards), 8'(m_mwb));
            chk("rnd we_valid", 8'(we_valid), 8'(m_we));
            chk("rnd stall", 8'(stall), 8'(m_st));
            chk("rnd bubble_ex", 8'(bubble_ex), 8'(m_bub));
            hold = m_st && !rst;
            tick();
        end

`ifdef HAZ_PERF_CNT_EN
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int it = 0; it < 3; it++) begin
            drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b0, 1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("perf stall_cnt x3", 8'(stall_cnt), 8'd6);
        chk("perf fwd_cnt zero", 8'(fwd_cnt), 8'd0);
        tick();
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("perf fwd_cnt one", 8'(fwd_cnt), 8'd1);
        tick();
        for (int it = 0; it < 10; it++) begin
            drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b0, 1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("perf stall_cnt saturate", 8'(stall_cnt), 8'(CW'('1)));
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
